// File: rtl/pc_pkg.sv
// Shared encodings for the program-counter unit: FSM states and the cause
// of a latched (pending) redirect.
package pc_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } pc_state_e;

  // Ordered so that a larger value is a higher-priority redirect
  typedef enum logic [1:0] {
    CAUSE_NONE   = 2'd0,
    CAUSE_BRANCH = 2'd1,
    CAUSE_JUMP   = 2'd2,
    CAUSE_EXC    = 2'd3
  } pc_cause_e;

endpackage

// File: rtl/pc_unit_if.sv
// Request/response bundle between the redirect sources, the fetch stage and
// pc_unit. The master side raises requests and stall; the slave side is the PC.
interface pc_unit_if #(
  parameter int WIDTH = 30
);
  logic             stall;
  logic             exc_en;
  logic             jump_en;
  logic [WIDTH-1:0] jump_tgt;
  logic             branch_en;
  logic [WIDTH-1:0] branch_tgt;
  logic [WIDTH-1:0] pc_out;
  logic [WIDTH-1:0] pc_seq;
  logic             fetch_valid;
  logic             redir_pend;

  modport master (
    output stall, exc_en, jump_en, jump_tgt, branch_en, branch_tgt,
    input  pc_out, pc_seq, fetch_valid, redir_pend
  );

  modport slave (
    input  stall, exc_en, jump_en, jump_tgt, branch_en, branch_tgt,
    output pc_out, pc_seq, fetch_valid, redir_pend
  );
endinterface

// File: rtl/pc_next_sel.sv
// Combinational next-PC selection: resolves this cycle's requests by priority
// and merges them with the pending redirect.
module pc_next_sel
  import pc_pkg::*;
#(
  parameter int          WIDTH   = 30,
  parameter int unsigned EXC_VEC = 32'h20,
  parameter int unsigned STEP    = 1
) (
  input  logic [WIDTH-1:0] pc,
  input  logic             exc_en,
  input  logic             jump_en,
  input  logic [WIDTH-1:0] jump_tgt,
  input  logic             branch_en,
  input  logic [WIDTH-1:0] branch_tgt,
  input  pc_cause_e        pend_cause,
  input  logic [WIDTH-1:0] pend_tgt,
  output logic [WIDTH-1:0] next_pc,
  output pc_cause_e        next_cause
);

  pc_cause_e        cur_cause;
  logic [WIDTH-1:0] cur_tgt;
  logic             take_cur;

  always_comb begin
    cur_cause = CAUSE_NONE;
    cur_tgt   = pc + WIDTH'(STEP);
    if (exc_en) begin
      cur_cause = CAUSE_EXC;
      cur_tgt   = WIDTH'(EXC_VEC);
    end else if (jump_en) begin
      cur_cause = CAUSE_JUMP;
      cur_tgt   = jump_tgt;
    end else if (branch_en) begin
      cur_cause = CAUSE_BRANCH;
      cur_tgt   = branch_tgt;
    end
  end

  // A fresh request wins over the pending one unless only an exception is pending
  assign take_cur = (cur_cause == CAUSE_EXC) ||
                    ((cur_cause != CAUSE_NONE) && (pend_cause != CAUSE_EXC));

  always_comb begin
    next_cause = cur_cause;
    next_pc    = cur_tgt;
    if (!take_cur && (pend_cause != CAUSE_NONE)) begin
      next_cause = pend_cause;
      next_pc    = pend_tgt;
    end
  end

endmodule

// File: rtl/pc_unit.sv
// Program counter with priority redirects, a stall hold state and a one-entry
// pending-redirect register. All state updates on the falling clock edge.
module pc_unit
  import pc_pkg::*;
#(
  parameter int          WIDTH     = 30,
  parameter int unsigned RESET_VEC = 0,
  parameter int unsigned EXC_VEC   = 32'h20,
  parameter int unsigned STEP      = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             exc_en,
  input  logic             jump_en,
  input  logic [WIDTH-1:0] jump_tgt,
  input  logic             branch_en,
  input  logic [WIDTH-1:0] branch_tgt,
  output logic [WIDTH-1:0] pc_out,
  output logic [WIDTH-1:0] pc_seq,
  output logic             fetch_valid,
  output logic             redir_pend,
  output pc_state_e        state_dbg
);

  pc_state_e        state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic             fv_q, fv_d;
  logic             rp_q, rp_d;
  pc_cause_e        pcause_q, pcause_d;
  logic [WIDTH-1:0] ptgt_q, ptgt_d;
  logic [WIDTH-1:0] next_pc;
  pc_cause_e        next_cause;

  pc_next_sel #(.WIDTH(WIDTH), .EXC_VEC(EXC_VEC), .STEP(STEP)) u_sel (
    .pc         (pc_q),
    .exc_en     (exc_en),
    .jump_en    (jump_en),
    .jump_tgt   (jump_tgt),
    .branch_en  (branch_en),
    .branch_tgt (branch_tgt),
    .pend_cause (pcause_q),
    .pend_tgt   (ptgt_q),
    .next_pc    (next_pc),
    .next_cause (next_cause)
  );

  // Handshake: pc_out is offered whenever fetch_valid=1 and is consumed on a
  // falling edge with stall=0; stall=1 means not-ready, so pc_out must hold.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    fv_d     = fv_q;
    rp_d     = rp_q;
    pcause_d = pcause_q;
    ptgt_d   = ptgt_q;
    case (state_q)
      ST_BOOT: begin
        state_d = ST_RUN;
        fv_d    = 1'b1;
      end
      ST_RUN, ST_HOLD: begin
        if (stall) begin
          state_d  = ST_HOLD;
          fv_d     = 1'b0;
          pcause_d = next_cause;
          rp_d     = (next_cause != CAUSE_NONE);
          if (next_cause != CAUSE_NONE) ptgt_d = next_pc;
        end else begin
          state_d  = ST_RUN;
          pc_d     = next_pc;
          fv_d     = 1'b1;
          rp_d     = 1'b0;
          pcause_d = CAUSE_NONE;
        end
      end
      default: state_d = ST_BOOT;
    endcase
  end

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_BOOT;
      pc_q     <= WIDTH'(RESET_VEC);
      fv_q     <= 1'b0;
      rp_q     <= 1'b0;
      pcause_q <= CAUSE_NONE;
      ptgt_q   <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      fv_q     <= fv_d;
      rp_q     <= rp_d;
      pcause_q <= pcause_d;
      ptgt_q   <= ptgt_d;
    end
  end

  assign pc_out      = pc_q;
  assign pc_seq      = pc_q + WIDTH'(STEP);
  assign fetch_valid = fv_q;
  assign redir_pend  = rp_q;
  assign state_dbg   = state_q;

endmodule
